// File: rtl/instr_fetch.sv
// instr_fetch: two-state (FETCH/EXEC) instruction fetch unit holding pc and the current instruction
// Ports: clk, rst_n (async active-low); imem_req/imem_addr/imem_ack/imem_rdata fetch handshake;
//        instr/instr_valid/opc/funct/pc/pc_plus4 current instruction view; ex_done, pc_src, jmp,
//        jr, jal, jr_target next-pc controls; trap pulses the cycle after a misaligned jr retires.
// Macro INSTR_FETCH_MISALIGN_TRAP_EN: misaligned jr redirects to TRAP_PC and pulses trap;
//        when undefined, jr_target[1:0] is forced to 00 and trap stays 0.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opc,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        ex_done,
  input  logic        pc_src,
  input  logic        jmp,
  input  logic        jr,
  input  logic        jal,
  input  logic [31:0] jr_target,
  output logic        trap
);
  typedef enum logic {FETCH, EXEC} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc, jr_dest, br_off;
  logic        trap_q, trap_d, jr_bad;
  assign pc_plus4    = pc_q + 32'd4;
  assign br_off      = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  assign jr_bad  = jr_target[1:0] != 2'b00;
  assign jr_dest = jr_bad ? TRAP_PC : jr_target;
`else
  logic unused_ok;
  assign unused_ok = ^{TRAP_PC, jr_target[1:0]};
  assign jr_bad    = 1'b0;
  assign jr_dest   = {jr_target[31:2], 2'b00};
`endif
  // jal implies a jump even when the controller leaves jmp low
  assign next_pc = jr          ? jr_dest :
                   (jmp | jal) ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
                   pc_src      ? pc_plus4 + br_off :
                                 pc_plus4;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign opc       = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign trap      = trap_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    trap_d      = 1'b0;
    imem_req    = state_q == FETCH;
    instr_valid = state_q == EXEC;
    if (state_q == FETCH) begin
      state_d = imem_ack ? EXEC : FETCH;
      instr_d = imem_ack ? imem_rdata : instr_q;
    end else if (ex_done) begin
      state_d = FETCH;
      pc_d    = next_pc;
      trap_d  = jr & jr_bad;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      trap_q  <= trap_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch against a next-pc reference model
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0080;
  logic clk = 0, rst_n = 0, imem_ack = 0, ex_done = 0, pc_src = 0, jmp = 0, jr = 0, jal = 0;
  logic [31:0] imem_rdata = 0, jr_target = 0;
  logic imem_req, instr_valid, trap;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0] opc, funct;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] addr_q[$];
  logic [63:0] exp_q[$];
  logic trap_q[$];
  logic [31:0] model_pc;
  always #5 clk = ~clk;
  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid), .opc(opc), .funct(funct),
    .pc(pc), .pc_plus4(pc_plus4), .ex_done(ex_done), .pc_src(pc_src), .jmp(jmp), .jr(jr),
    .jal(jal), .jr_target(jr_target), .trap(trap)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: scoreboard queue empty at %0t", nm, $time);
  endtask
  // reference next-pc rule: returns {trap, next pc}
  function automatic logic [32:0] ref_next(input logic [31:0] p, input logic [31:0] w,
      input logic ps, input logic jm, input logic jrr, input logic jl, input logic [31:0] t);
    logic [31:0] seq;
    int off;
    seq = p + 32'd4;
    if (jrr) begin
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      if (t % 4 != 0) return {1'b1, TRP_PC};
      return {1'b0, t};
`else
      return {1'b0, t - (t % 4)};
`endif
    end
    if (jm || jl) return {1'b0, (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4)};
    if (ps) begin
      off = $signed(w[15:0]);
      return {1'b0, seq + 32'(off * 4)};
    end
    return {1'b0, seq};
  endfunction
  initial begin
    logic v_prev, ex_prev, et;
    logic [63:0] cur;
    v_prev = 0;
    ex_prev = 0;
    cur = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        v_prev = 0;
        ex_prev = 0;
      end else begin
        if (imem_req && imem_ack) begin
          if (addr_q.size() == 0) miss("fetch_addr");
          else chk("fetch_addr", imem_addr, addr_q.pop_front());
          chk("valid_in_fetch", instr_valid, 0);
        end
        if (instr_valid) begin
          if (!v_prev) begin
            if (exp_q.size() == 0) miss("exec_entry");
            else begin
              cur = exp_q.pop_front();
              chk("pc", pc, cur[63:32]);
              chk("pc_plus4", pc_plus4, cur[63:32] + 32'd4);
              chk("opc", opc, 32'(cur[31:26]));
              chk("funct", funct, 32'(cur[5:0]));
            end
          end
          chk("instr_held", instr, cur[31:0]);
          chk("req_in_exec", imem_req, 0);
        end
        et = 0;
        if (ex_prev) begin
          if (trap_q.size() == 0) miss("trap");
          else et = trap_q.pop_front();
        end
        chk("trap", trap, et);
        ex_prev = instr_valid && ex_done;
        v_prev = instr_valid;
      end
    end
  end
  task automatic rnd_ctl();
    ex_done = 1'($urandom);
    pc_src = 1'($urandom);
    jmp = 1'($urandom);
    jr = 1'($urandom);
    jal = 1'($urandom);
    jr_target = $urandom;
  endtask
  task automatic do_instr(input logic [31:0] w, input int ad, input int ed, input logic ps,
      input logic jm, input logic jrr, input logic jl, input logic [31:0] t);
    int n;
    logic [32:0] r;
    n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) begin
      miss("fetch_timeout");
      return;
    end
    repeat (ad) begin
      rnd_ctl();
      imem_rdata = $urandom;
      @(posedge clk); #1;
    end
    ex_done = 0;
    imem_ack = 1;
    imem_rdata = w;
    addr_q.push_back(model_pc);
    exp_q.push_back({model_pc, w});
    @(posedge clk); #1;
    imem_ack = 0;
    imem_rdata = $urandom;
    repeat (ed) begin
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      @(posedge clk); #1;
    end
    imem_ack = 0;
    ex_done = 1;
    pc_src = ps; jmp = jm; jr = jrr; jal = jl; jr_target = t;
    r = ref_next(model_pc, w, ps, jm, jrr, jl, t);
    trap_q.push_back(r[32]);
    model_pc = r[31:0];
    @(posedge clk); #1;
    ex_done = 0; pc_src = 0; jmp = 0; jr = 0; jal = 0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] t;
    int sel;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_trap", trap, 0);
    model_pc = RST_PC;
    rst_n = 1;
    chk("req_after_reset", imem_req, 1);
    do_instr(32'h0000_0020, 1, 0, 0, 0, 0, 0, 0);
    do_instr(32'h1234_5678, 0, 1, 0, 0, 0, 0, 0);
    do_instr(32'h0000_FFFE, 0, 1, 1, 0, 0, 0, 0);
    do_instr(32'hABCD_0001, 2, 0, 1, 1, 1, 0, 32'h1000_0000);
    do_instr(32'h0C00_0010, 0, 2, 0, 1, 0, 1, 0);
    do_instr(32'h8765_4321, 1, 0, 1, 1, 1, 0, 32'h0000_0200);
    do_instr(32'h0000_0008, 0, 0, 0, 0, 1, 0, 32'h0000_0202);
    do_instr(32'h0F0F_0F0F, 0, 1, 0, 0, 0, 0, 0);
    do_instr(32'h0000_1234, 0, 0, 1, 0, 0, 1, 0);
    do_instr(32'h0000_0000, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC);
    do_instr(32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 0);
    do_instr(32'h0000_7FFF, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      t = $urandom;
      if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
      do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom),
               sel == 1 || $urandom_range(0, 3) == 0, sel == 0, sel == 2, t);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_addr", imem_addr, RST_PC);
    chk("midrst_instr", instr, 0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_trap", trap, 0);
    addr_q.delete();
    exp_q.delete();
    trap_q.delete();
    imem_ack = 1;
    imem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    chk("rstack_instr", instr, 0);
    chk("rstack_valid", instr_valid, 0);
    imem_ack = 0;
    model_pc = RST_PC;
    rst_n = 1;
    chk("req_after_rst2", imem_req, 1);
    chk("addr_after_rst2", imem_addr, RST_PC);
    do_instr(32'h0000_0020, 2, 0, 0, 0, 0, 0, 0);
    do_instr(32'h1111_2222, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
